// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : approx_mult_pipe
//  Purpose  : Three-stage pipelined unsigned multiplier with per-beat choice
//             of exact or approximate product and a valid/ready stream port.
//             Approximate mode multiplies the top EXACT_ROWS rows of x
//             exactly. The remaining rows are OR-compressed in pairs, and
//             their product columns below L are dropped.
//  Ports    : clk, rst                   clock, synchronous active-high reset
//             in_valid/in_ready, x, y,   operand beat input stream
//             mode                       (mode 1 = approximate)
//             out_valid/out_ready, z,    product output stream
//             out_mode                   (mode carried with the result)
//             stat_clr, err_count,       approximate-result error statistics
//             err_sum
//  Options  : APPROX_ERR_STAT_EN - builds a shadow exact product path and the
//             saturating error counters. When it is not defined, both
//             counters read 0 and stat_clr has no effect.
//  Revision : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
    parameter int WIDTH      = 8,
    parameter int L          = 6,
    parameter int EXACT_ROWS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               out_mode,
    input  logic               stat_clr,
    output logic [31:0]        err_count,
    output logic [31:0]        err_sum
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_SPLIT = WIDTH - EXACT_ROWS;   // first exactly multiplied row
    localparam int c_PAIRS = c_SPLIT / 2;
    // Columns at or above L survive in the compressed lower rows
    localparam logic [c_PW-1:0] c_LO_MASK = {c_PW{1'b1}} << L;

    logic               w_adv;
    logic               r_v1, r_v2, r_v3;
    logic [WIDTH-1:0]   r_x, r_y;
    logic               r_mode1, r_mode2, r_mode3;
    logic [c_PW-1:0]    r_hi2, r_lo2, r_z;

    logic [c_PW-1:0]    w_row, w_pa, w_pb;
    logic [c_PW-1:0]    w_hi, w_lo_exact, w_lo_apx, w_lo_sel;

    // Every stage moves together. Nothing moves while a result is held.
    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign z         = r_z;
    assign out_mode  = r_mode3;

    always_comb begin
        w_row      = '0;
        w_pa       = '0;
        w_pb       = '0;
        w_hi       = '0;
        w_lo_exact = '0;
        w_lo_apx   = '0;
        // The upper rows and the exact lower rows are split at the same
        // boundary. As a result, stage 2 holds a (high, low) pair in both modes.
        for (int i = 0; i < WIDTH; i++) begin
            w_row = {{WIDTH{1'b0}}, r_y & {WIDTH{r_x[i]}}} << i;
            if (i >= c_SPLIT) begin
                w_hi = w_hi + w_row;
            end else begin
                w_lo_exact = w_lo_exact + w_row;
            end
        end
        // OR-ing two shifted rows gives the per-column OR of the two
        // partial-product terms. Out-of-range y indices are zero by shifting.
        for (int k = 0; k < c_PAIRS; k++) begin
            w_pa     = {{WIDTH{1'b0}}, r_y & {WIDTH{r_x[2*k]}}}   << (2*k);
            w_pb     = {{WIDTH{1'b0}}, r_y & {WIDTH{r_x[2*k+1]}}} << (2*k+1);
            w_lo_apx = w_lo_apx + ((w_pa | w_pb) & c_LO_MASK);
        end
    end

    assign w_lo_sel = r_mode1 ? w_lo_apx : w_lo_exact;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_mode1 <= 1'b0;
            r_mode2 <= 1'b0;
            r_mode3 <= 1'b0;
            r_hi2   <= '0;
            r_lo2   <= '0;
            r_z     <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_x     <= x;
            r_y     <= y;
            r_mode1 <= mode;
            r_v2    <= r_v1;
            r_hi2   <= w_hi;
            r_lo2   <= w_lo_sel;
            r_mode2 <= r_mode1;
            r_v3    <= r_v2;
            r_z     <= r_hi2 + r_lo2;
            r_mode3 <= r_mode2;
        end
    end

`ifdef APPROX_ERR_STAT_EN
    // Headroom wide enough that the accumulator add can never wrap
    localparam int c_SW = c_PW + 33;

    logic [c_PW-1:0] r_exact2, r_exact3;
    logic [31:0]     r_err_count, r_err_sum;
    logic            w_xfer_apx;
    logic [c_PW-1:0] w_err;
    logic [c_SW-1:0] w_sum_wide;

    assign w_xfer_apx = r_v3 && out_ready && r_mode3;
    assign w_err      = r_exact3 - r_z;   // never negative: approx <= exact
    assign w_sum_wide = {{(c_SW-32){1'b0}}, r_err_sum} + {{(c_SW-c_PW){1'b0}}, w_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exact2 <= '0;
            r_exact3 <= '0;
        end else if (w_adv) begin
            r_exact2 <= w_hi + w_lo_exact;
            r_exact3 <= r_exact2;
        end
    end

    // A clear on the same edge as a counted transfer takes priority
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
        end else if (w_xfer_apx) begin
            if (r_err_count != 32'hFFFF_FFFF) begin
                r_err_count <= r_err_count + 32'd1;
            end
            if (|w_sum_wide[c_SW-1:32]) begin
                r_err_sum <= 32'hFFFF_FFFF;
            end else begin
                r_err_sum <= w_sum_wide[31:0];
            end
        end
    end

    assign err_count = r_err_count;
    assign err_sum   = r_err_sum;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;
    assign err_count         = '0;
    assign err_sum           = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_approx_mult_pipe
//  Purpose  : Self-checking bench for approx_mult_pipe (WIDTH=8, L=6,
//             EXACT_ROWS=2). Expected products come from a column-by-column
//             model of the approximation rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

    localparam int c_TW  = 8;
    localparam int c_TL  = 6;
    localparam int c_TER = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] z;
    logic        out_mode;
    logic        stat_clr = 1'b0;
    logic [31:0] err_count;
    logic [31:0] err_sum;

    int n_vec = 0;
    int n_err = 0;

    logic [16:0] acc_q[$];   // {mode, x, y} of accepted beats
    logic [16:0] out_q[$];   // {out_mode, z} of delivered results

    always #5 clk = ~clk;

    approx_mult_pipe #(.WIDTH(c_TW), .L(c_TL), .EXACT_ROWS(c_TER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .out_mode  (out_mode),
        .stat_clr  (stat_clr),
        .err_count (err_count),
        .err_sum   (err_sum)
    );

    // Handshakes are recorded mid-cycle, ahead of the edge that completes them
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) acc_q.push_back({mode, x, y});
            if (out_valid && out_ready) out_q.push_back({out_mode, z});
        end
    end

    // Approximate product built column by column from the row/pair rules
    function automatic int unsigned ref_approx(input int unsigned a, input int unsigned b);
        int unsigned up, lo;
        int          j0, j1;
        bit          t0, t1;
        up = (b * (a >> (c_TW - c_TER))) << (c_TW - c_TER);
        lo = 0;
        for (int c = c_TL; c < 2 * c_TW; c++) begin
            for (int k = 0; k < (c_TW - c_TER) / 2; k++) begin
                j0 = c - 2 * k;
                j1 = c - 2 * k - 1;
                t0 = ((a >> (2 * k)) & 1) == 1 && j0 >= 0 && j0 < c_TW && ((b >> j0) & 1) == 1;
                t1 = ((a >> (2 * k + 1)) & 1) == 1 && j1 >= 0 && j1 < c_TW && ((b >> j1) & 1) == 1;
                if (t0 || t1) lo = lo + (32'd1 << c);
            end
        end
        return up + lo;
    endfunction

    function automatic int unsigned ref_prod(input int unsigned a, input int unsigned b, input bit m);
        return m ? ref_approx(a, b) : a * b;
    endfunction

    task automatic send_beat(input int a, input int b, input bit m);
        x = 8'(a);
        y = 8'(b);
        mode = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int bound, output bit timed_out);
        int cyc;
        cyc = 0;
        while (out_q.size() < n && cyc < bound) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        timed_out = (out_q.size() < n);
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0d want 1", in_ready); end
        n_vec++; if (z !== 16'd0) begin n_err++; $display("FAIL reset_z: got %0d want 0", z); end
        n_vec++; if (out_mode !== 1'b0) begin n_err++; $display("FAIL reset_out_mode: got %0d want 0", out_mode); end
        n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        n_vec++; if (err_sum !== 32'd0) begin n_err++; $display("FAIL reset_err_sum: got %0d want 0", err_sum); end
        acc_q.delete();
        out_q.delete();
    endtask

    // Edge count includes the accepting edge: S1, S2, S3
    task automatic test_exact_max();
        acc_q.delete();
        out_q.delete();
        x = 8'd255; y = 8'd255; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got out_valid=%0d want 0", out_valid); end
        @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: got out_valid=%0d want 1", out_valid); end
        n_vec++; if (z !== 16'd65025) begin n_err++; $display("FAIL exact_max_z: got %0d want 65025", z); end
        n_vec++; if (out_mode !== 1'b0) begin n_err++; $display("FAIL exact_max_mode: got %0d want 0", out_mode); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_approx_pair();
        bit to;
        int cyc;
        logic [31:0] want_cnt, want_sum;
        pulse_clr();
        acc_q.delete();
        out_q.delete();
        send_beat(255, 255, 1'b1);
        send_beat(1, 255, 1'b1);
        wait_out(2, 50, to);
        n_vec++; if (to) begin n_err++; $display("FAIL approx_pair_timeout: got %0d results want 2", out_q.size()); end
        if (!to) begin
            n_vec++; if (out_q[0] !== {1'b1, 16'd59520}) begin n_err++; $display("FAIL approx_255x255: got %0d want 59520 (mode %0d)", out_q[0][15:0], out_q[0][16]); end
            n_vec++; if (out_q[1] !== {1'b1, 16'd192}) begin n_err++; $display("FAIL approx_1x255: got %0d want 192 (mode %0d)", out_q[1][15:0], out_q[1][16]); end
        end
`ifdef APPROX_ERR_STAT_EN
        want_cnt = 32'd2;
        want_sum = 32'd5568;
`else
        want_cnt = 32'd0;
        want_sum = 32'd0;
`endif
        n_vec++; if (err_count !== want_cnt) begin n_err++; $display("FAIL stat_count: got %0d want %0d", err_count, want_cnt); end
        n_vec++; if (err_sum !== want_sum) begin n_err++; $display("FAIL stat_sum: got %0d want %0d", err_sum, want_sum); end
        // Clear coinciding with a counted transfer
        send_beat(255, 255, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++; if (!out_valid) begin n_err++; $display("FAIL clr_race_timeout: got out_valid=0 want 1"); end
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        n_vec++; if (err_count !== 32'd0) begin n_err++; $display("FAIL clr_race_count: got %0d want 0", err_count); end
        n_vec++; if (err_sum !== 32'd0) begin n_err++; $display("FAIL clr_race_sum: got %0d want 0", err_sum); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_exact_rows();
        bit to;
        acc_q.delete();
        out_q.delete();
        send_beat(192, 200, 1'b1);
        wait_out(1, 50, to);
        n_vec++; if (to) begin n_err++; $display("FAIL top_rows_timeout: got 0 results want 1"); end
        if (!to) begin
            n_vec++; if (out_q[0] !== {1'b1, 16'd38400}) begin n_err++; $display("FAIL top_rows_z: got %0d want 38400", out_q[0][15:0]); end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [7:0]  bx[4];
        logic [7:0]  by[4];
        bit          bm[4];
        int          bi;
        bit          accepted, was_stalled, to;
        logic [15:0] prev_z;
        logic        prev_m;
        logic [16:0] want;
        acc_q.delete();
        out_q.delete();
        for (int i = 0; i < 4; i++) begin
            bx[i] = 8'($urandom);
            by[i] = 8'($urandom);
            bm[i] = 1'($urandom);
        end
        bi = 0;
        was_stalled = 1'b0;
        prev_z = '0;
        prev_m = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            in_valid  = (bi < 4);
            x         = bx[bi < 4 ? bi : 0];
            y         = by[bi < 4 ? bi : 0];
            mode      = bm[bi < 4 ? bi : 0];
            out_ready = !(cyc >= 5 && cyc <= 7);
            #3;
            if (!out_ready && out_valid) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: cycle %0d got %0d want 0", cyc, in_ready); end
                if (was_stalled) begin
                    n_vec++; if (z !== prev_z || out_mode !== prev_m) begin n_err++; $display("FAIL stall_hold: cycle %0d got %0d want %0d", cyc, z, prev_z); end
                end
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            prev_z = z;
            prev_m = out_mode;
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) bi++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_out(4, 50, to);
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (out_q.size() != 4) begin n_err++; $display("FAIL stall_count: got %0d results want 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            want = {bm[i], 16'(ref_prod(bx[i], by[i], bm[i]))};
            n_vec++; if (out_q[i] !== want) begin n_err++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, out_q[i], want); end
        end
    endtask

    task automatic test_reset_midstream();
        acc_q.delete();
        out_q.delete();
        out_ready = 1'b1;
        send_beat(255, 255, 1'b1);
        send_beat(37, 201, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %0d want 0", out_valid); end
        repeat (6) @(posedge clk);
        #1;
        n_vec++; if (out_q.size() != 0) begin n_err++; $display("FAIL midrst_emitted: got %0d results want 0", out_q.size()); end
        n_vec++; if (err_count !== 32'd0 || err_sum !== 32'd0) begin n_err++; $display("FAIL midrst_stats: got %0d/%0d want 0/0", err_count, err_sum); end
        acc_q.delete();
    endtask

    task automatic test_random();
        bit          to;
        int          cyc, n;
        int unsigned a, b, ex, want;
        bit          m;
        logic [31:0] exp_cnt, exp_sum;
        pulse_clr();
        acc_q.delete();
        out_q.delete();
        cyc = 0;
        while (acc_q.size() < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            x         = 8'($urandom);
            y         = 8'($urandom);
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = acc_q.size();
        wait_out(n, 100, to);
        n_vec++; if (n != 10000 || out_q.size() != n) begin n_err++; $display("FAIL rand_count: got %0d results for %0d beats want 10000", out_q.size(), n); end
        exp_cnt = 0;
        exp_sum = 0;
        for (int i = 0; i < n && i < out_q.size(); i++) begin
            m    = acc_q[i][16];
            a    = acc_q[i][15:8];
            b    = acc_q[i][7:0];
            ex   = a * b;
            want = ref_prod(a, b, m);
            n_vec++;
            if (out_q[i] !== {m, 16'(want)} || out_q[i][15:0] > ex) begin
                n_err++;
                $display("FAIL rand_beat[%0d]: x=%0d y=%0d mode=%0d got %0d/%0d want %0d/%0d", i, a, b, m, out_q[i][15:0], out_q[i][16], want, m);
            end
            if (m) begin
                exp_cnt = exp_cnt + 1;
                exp_sum = exp_sum + (ex - want);
            end
        end
`ifndef APPROX_ERR_STAT_EN
        exp_cnt = 0;
        exp_sum = 0;
`endif
        n_vec++; if (err_count !== exp_cnt) begin n_err++; $display("FAIL rand_err_count: got %0d want %0d", err_count, exp_cnt); end
        n_vec++; if (err_sum !== exp_sum) begin n_err++; $display("FAIL rand_err_sum: got %0d want %0d", err_sum, exp_sum); end
    endtask

    initial begin
        test_reset();
        test_exact_max();
        test_approx_pair();
        test_exact_rows();
        test_back_to_back_stall();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
